// File: rtl/nibble_frame_collector_if.sv
// rtl/nibble_frame_collector_if.sv - payload nibble stream between collector and consumer
//
// Signals:
//   out_valid  collector -> consumer  head nibble available
//   out_data   collector -> consumer  head nibble (4'h0 when nothing is held)
//   out_ready  consumer -> collector  consumer accepts the head nibble this clock
// Modports:
//   master  the collector (drives valid/data, observes ready)
//   slave   the consumer  (observes valid/data, drives ready)

interface nibble_frame_collector_if;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/nibble_frame_collector.sv
// rtl/nibble_frame_collector.sv - hunts a sync nibble in a shift-register window and queues payload nibbles
//
// Samples the parallel output of a 4-bit serial-in shift register every clock.
// In HUNT it looks for SYNC_PAT; once found it captures every 4th window as a
// payload nibble until FRAME_NIBBLES nibbles are taken, then hunts again.
// Captured nibbles go through a first-word fall-through FIFO.
//
// Optional feature macro: FRAME_CNT_EN (completed-frame counter on frame_cnt).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   shift_q    in   [3:0] shift register parallel output
//   stream     master modport of nibble_frame_collector_if (out_valid/out_data/out_ready)
//   locked     out  registered, 1 while in LOCKED
//   overflow   out  sticky, a payload nibble was dropped because the FIFO was full
//   frame_cnt  out  [FCNT_W-1:0] completed frames (0 when FRAME_CNT_EN is undefined)

module nibble_frame_collector #(
    parameter logic [3:0] SYNC_PAT      = 4'b1011,
    parameter int         FRAME_NIBBLES = 2,
    parameter int         FIFO_DEPTH    = 4,
    parameter int         FCNT_W        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 shift_q,
    nibble_frame_collector_if.master   stream,
    output logic                       locked,
    output logic                       overflow,
    output logic [FCNT_W-1:0]          frame_cnt
);

    localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] LAST_NIB = 4'(FRAME_NIBBLES - 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] bit_cnt;
    logic [3:0] nib_cnt;
    logic       capture;
    logic       frame_done;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HUNT;
            locked <= 1'b0;
        end else begin
            state  <= state_next;
            locked <= (state_next == LOCKED);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (shift_q == SYNC_PAT) state_next = LOCKED;
            LOCKED:  if (frame_done)          state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // bit_cnt==3 means four fresh bits have entered the window since the
    // sync match or the previous capture.
    always_comb begin
        capture    = 1'b0;
        frame_done = 1'b0;
        if (state == LOCKED && bit_cnt == 2'd3) begin
            capture    = 1'b1;
            frame_done = (nib_cnt == LAST_NIB);
        end
    end

    // Bit/nibble position within the frame; held at zero while hunting so the
    // match edge starts the frame from a clean count.
    always_ff @(posedge clk) begin
        if (rst || state == HUNT) begin
            bit_cnt <= 2'd0;
            nib_cnt <= 4'd0;
        end else begin
            bit_cnt <= bit_cnt + 2'd1;
            if (capture) begin
                nib_cnt <= frame_done ? 4'd0 : nib_cnt + 4'd1;
            end
        end
    end

    // ---------------- payload FIFO ----------------
    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = !empty && stream.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    assign stream.out_valid = !empty;
    assign stream.out_data  = empty ? 4'h0 : mem[rptr];

    // ---------------- frame counter ----------------
`ifdef FRAME_CNT_EN
    // Counts every completed frame, including ones whose nibbles were dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_nibble_frame_collector.sv
// tb/tb_nibble_frame_collector.sv - self-checking bench for nibble_frame_collector

module tb_nibble_frame_collector;

    localparam int         FN    = 2;
    localparam int         DEPTH = 4;
    localparam logic [3:0] SYNC  = 4'b1011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] shift_q = 4'h0;
    logic [3:0] sr = 4'h0;
    logic       locked;
    logic       overflow;
    logic [7:0] frame_cnt;

    int nvec  = 0;
    int nfail = 0;

    nibble_frame_collector_if bus ();

    nibble_frame_collector #(
        .SYNC_PAT      (SYNC),
        .FRAME_NIBBLES (FN),
        .FIFO_DEPTH    (DEPTH),
        .FCNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .shift_q   (shift_q),
        .stream    (bus),
        .locked    (locked),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is a window of 4*FN clocks after a sync match; every 4th clock
    // inside it yields a payload nibble. The FIFO is a plain bounded queue.
    bit         m_ok = 1'b0;
    bit         m_in = 1'b0;
    int         m_since = 0;
    logic [3:0] m_q[$];
    bit         m_ovf = 1'b0;
    int         m_fcnt = 0;
    int         m_pre;
    bit         m_pop;
    bit         m_cap;
    bit         m_done;

    always @(posedge clk) begin
        if (rst) begin
            m_ok    = 1'b1;
            m_in    = 1'b0;
            m_since = 0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_fcnt  = 0;
        end else begin
            m_pre  = m_q.size();
            m_pop  = (m_pre > 0) && (bus.out_ready === 1'b1);
            m_cap  = 1'b0;
            m_done = 1'b0;
            if (m_in) begin
                m_since++;
                if (m_since % 4 == 0) m_cap = 1'b1;
                if (m_since == 4 * FN) begin
                    m_in   = 1'b0;
                    m_done = 1'b1;
                end
            end else if (shift_q == SYNC) begin
                m_in    = 1'b1;
                m_since = 0;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_cap) begin
                if (m_pre == DEPTH && !m_pop) m_ovf = 1'b1;
                else m_q.push_back(shift_q);
            end
            if (m_done) m_fcnt = (m_fcnt + 1) % 256;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_ok) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
            chk("out_data",  32'(bus.out_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
            chk("locked",    32'(locked),        32'(m_in));
            chk("overflow",  32'(overflow),      32'(m_ovf));
`ifdef FRAME_CNT_EN
            chk("frame_cnt", 32'(frame_cnt),     32'(m_fcnt));
`else
            chk("frame_cnt", 32'(frame_cnt),     32'h0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] got[$];

    // One clock: shift bit b into the register, set ready and reset, then
    // wait for the next falling edge. A handshake is recorded when the DUT
    // presents valid while ready is being offered for the coming edge.
    task automatic tick(input logic b, input logic r, input logic rs);
        sr = {sr[2:0], b};
        shift_q = sr;
        bus.out_ready = r;
        rst = rs;
        if (!rs && r && bus.out_valid === 1'b1) got.push_back(bus.out_data);
        @(negedge clk);
    endtask

    task automatic send_nib(input logic [3:0] n, input logic r_mid, input logic r_last);
        for (int i = 3; i >= 0; i--) tick(n[i], (i == 0) ? r_last : r_mid, 1'b0);
    endtask

    task automatic pad(input logic r);
        for (int i = 0; i < 4; i++) tick(1'b0, r, 1'b0);
    endtask

    task automatic chk_seq(input string name, input int n, input logic [31:0] seq);
        chk({name, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk(name, 32'(got[i]), 32'(seq[4*(n-1-i) +: 4]));
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        @(negedge clk);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);

        // T1: reset in the middle of a frame
        pad(1'b0);
        send_nib(SYNC, 1'b0, 1'b0);
        send_nib(4'h6, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk("t1_valid",     32'(bus.out_valid), 32'h0);
        chk("t1_data",      32'(bus.out_data),  32'h0);
        chk("t1_locked",    32'(locked),        32'h0);
        chk("t1_overflow",  32'(overflow),      32'h0);
        chk("t1_frame_cnt", 32'(frame_cnt),     32'h0);

        // T2: one frame A,5 with the consumer always ready
        got.delete();
        pad(1'b1);
        send_nib(SYNC, 1'b1, 1'b1);
        chk("t2_locked_after_match", 32'(locked), 32'h1);
        send_nib(4'hA, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("t2_locked_edge7", 32'(locked), 32'h1);
        tick(1'b1, 1'b1, 1'b0);
        chk("t2_locked_edge8", 32'(locked), 32'h0);
        pad(1'b1);
        chk_seq("t2_data", 2, 32'hA5);

        // T3: consumer stalled across three frames, FIFO overflows
        got.delete();
        for (int f = 0; f < 3; f++) begin
            pad(1'b0);
            send_nib(SYNC, 1'b0, 1'b0);
            send_nib(4'(2*f + 1), 1'b0, 1'b0);
            if (f == 2) chk("t3_overflow_after_5th", 32'(overflow), 32'h1);
            else if (f == 1) chk("t3_overflow_before_5th", 32'(overflow), 32'h0);
            send_nib(4'(2*f + 2), 1'b0, 1'b0);
        end
        pad(1'b1);
        pad(1'b1);
        chk("t3_overflow_sticky", 32'(overflow), 32'h1);
        chk_seq("t3_drain", 4, 32'h1234);

        // T4: reset right after the first payload push, then sync pattern as payload
        tick(1'b0, 1'b0, 1'b1);
        pad(1'b0);
        send_nib(SYNC, 1'b0, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0);
        chk("t4_valid_before_rst", 32'(bus.out_valid), 32'h1);
        tick(1'b0, 1'b0, 1'b1);
        chk("t4_valid_after_rst",  32'(bus.out_valid), 32'h0);
        chk("t4_locked_after_rst", 32'(locked),        32'h0);
        got.delete();
        pad(1'b1);
        send_nib(SYNC, 1'b1, 1'b1);
        send_nib(SYNC, 1'b1, 1'b1);
        send_nib(SYNC, 1'b1, 1'b1);
        pad(1'b1);
        pad(1'b1);
        chk_seq("t4_data", 2, 32'hBB);

        // T5: capture coincides with a pop while the FIFO is full
        tick(1'b0, 1'b0, 1'b1);
        got.delete();
        pad(1'b0);
        send_nib(SYNC, 1'b0, 1'b0);
        send_nib(4'h7, 1'b0, 1'b0);
        send_nib(4'h8, 1'b0, 1'b0);
        pad(1'b0);
        send_nib(SYNC, 1'b0, 1'b0);
        send_nib(4'h9, 1'b0, 1'b0);
        send_nib(4'hC, 1'b0, 1'b0);
        pad(1'b0);
        send_nib(SYNC, 1'b0, 1'b0);
        send_nib(4'hD, 1'b0, 1'b1);
        chk("t5_overflow_d", 32'(overflow), 32'h0);
        send_nib(4'hE, 1'b0, 1'b1);
        chk("t5_overflow_e", 32'(overflow), 32'h0);
        chk("t5_still_full", 32'(bus.out_data), 32'h9);
        // T6: three frames since the last reset
`ifdef FRAME_CNT_EN
        chk("t6_frame_cnt", 32'(frame_cnt), 32'h3);
`else
        chk("t6_frame_cnt", 32'(frame_cnt), 32'h0);
`endif
        pad(1'b1);
        pad(1'b0);
        chk_seq("t5_drain", 6, 32'h789CDE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
